// File: rtl/dma_transfer_sequencer.sv
// Multi-channel DMA sequencer: hold handshake with the CPU, fixed or rotating
// channel arbitration, and demand/single/block word transfers with terminal count.
module dma_transfer_sequencer #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      CS_N,
  input  logic [NUM_CH-1:0]         DREQ,
  input  logic                      HLDA,
  input  logic                      extEOP,
  input  logic [2*NUM_CH-1:0]       modeSel,
  input  logic                      rotatePriority,
  input  logic                      progWe,
  input  logic [$clog2(NUM_CH)-1:0] progCh,
  input  logic [ADDR_W-1:0]         progAddr,
  input  logic [CNT_W-1:0]          progCount,
  output logic                      HRQ,
  output logic [NUM_CH-1:0]         DACK,
  output logic [ADDR_W-1:0]         ADDR,
  output logic                      xferStrobe,
  output logic                      intEOP,
  output logic [NUM_CH-1:0]         tcStatus
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [2:0] {IDLE, HOLD_REQ, ARB, XFER, UPDATE} state_t;

  state_t            state, next_state;
  logic [CH_W-1:0]   cur_ch, prio, win_ch;
  logic [ADDR_W-1:0] addr_r  [NUM_CH];
  logic [CNT_W-1:0]  count_r [NUM_CH];
  logic [NUM_CH-1:0] tc_flags, eligible;
  logic              eop_pend, hold_pend;
  logic              win_found, in_svc, tc_hit, eop_stop, stop_now;
  logic [1:0]        cur_mode;
  int                base, idx;

  assign eligible = DREQ & ~tc_flags;
  assign in_svc   = (state == XFER) || (state == UPDATE);
  assign cur_mode = modeSel[{cur_ch, 1'b0} +: 2];
  assign eop_stop = eop_pend | extEOP;
  assign stop_now = eop_stop | hold_pend | ~HLDA;
  assign tc_hit   = (state == UPDATE) && (count_r[cur_ch] == '0) && !eop_stop;

  // Scan channels starting at the priority pointer (or channel 0 when fixed).
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    idx       = 0;
    base      = rotatePriority ? int'(prio) : 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = base + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!win_found && eligible[CH_W'(idx)]) begin
        win_found = 1'b1;
        win_ch    = CH_W'(idx);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (CS_N && |eligible) next_state = HOLD_REQ;
      HOLD_REQ: if (HLDA) next_state = ARB;
      ARB:      next_state = (HLDA && win_found) ? XFER : IDLE;
      XFER:     next_state = UPDATE;
      UPDATE: begin
        if (stop_now || tc_hit)                     next_state = IDLE;
        else if (cur_mode == 2'b10)                 next_state = XFER;
        else if (cur_mode == 2'b00 && DREQ[cur_ch]) next_state = XFER;
        else                                        next_state = IDLE;
      end
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    DACK = '0;
    if (in_svc) DACK[cur_ch] = 1'b1;
    HRQ        = (state != IDLE);
    ADDR       = in_svc ? addr_r[cur_ch] : '0;
    xferStrobe = (state == XFER);
    intEOP     = tc_hit;
    tcStatus   = tc_flags;
  end

  // Abort requests seen during XFER are remembered so the following UPDATE
  // still completes before the service is dropped.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cur_ch    <= '0;
      prio      <= '0;
      tc_flags  <= '0;
      eop_pend  <= 1'b0;
      hold_pend <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        addr_r[i]  <= '0;
        count_r[i] <= '0;
      end
    end else begin
      state <= next_state;
      if (state == ARB) begin
        cur_ch    <= win_ch;
        eop_pend  <= 1'b0;
        hold_pend <= 1'b0;
      end
      if (state == XFER) begin
        if (extEOP) eop_pend  <= 1'b1;
        if (!HLDA)  hold_pend <= 1'b1;
      end
      if (state == UPDATE) begin
        addr_r[cur_ch]  <= addr_r[cur_ch] + 1'b1;
        count_r[cur_ch] <= count_r[cur_ch] - 1'b1;
        if (tc_hit) tc_flags[cur_ch] <= 1'b1;
        if (next_state == IDLE) begin
          prio      <= (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
          eop_pend  <= 1'b0;
          hold_pend <= 1'b0;
        end
      end
      if (progWe && !(in_svc && progCh == cur_ch)) begin
        addr_r[progCh]   <= progAddr;
        count_r[progCh]  <= progCount;
        tc_flags[progCh] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dma_transfer_sequencer.sv
// Self-checking bench for dma_transfer_sequencer: scenario tasks compare observed
// strobes/flags against a word-level channel model kept in the bench.
module tb_dma_transfer_sequencer;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;

  logic        CLK = 1'b0;
  logic        RESET, CS_N, HLDA, extEOP, rotatePriority, progWe;
  logic [3:0]  DREQ;
  logic [7:0]  modeSel;
  logic [1:0]  progCh;
  logic [15:0] progAddr, progCount;
  logic        HRQ, xferStrobe, intEOP;
  logic [3:0]  DACK, tcStatus;
  logic [15:0] ADDR;

  int checks = 0;
  int failures = 0;

  logic [15:0] obs_addr[$];
  logic [3:0]  obs_dack[$];
  int          obs_cyc[$];
  int          eop_cnt, hrq_rise, cyc;
  logic        hrq_prev;

  logic [15:0] m_addr[NUM_CH];
  logic [15:0] m_cnt[NUM_CH];
  logic [3:0]  m_tc;
  int          m_ptr;
  logic [15:0] exp_addr[$];
  int          exp_ch[$];

  dma_transfer_sequencer #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .CS_N(CS_N), .DREQ(DREQ), .HLDA(HLDA),
    .extEOP(extEOP), .modeSel(modeSel), .rotatePriority(rotatePriority),
    .progWe(progWe), .progCh(progCh), .progAddr(progAddr), .progCount(progCount),
    .HRQ(HRQ), .DACK(DACK), .ADDR(ADDR), .xferStrobe(xferStrobe),
    .intEOP(intEOP), .tcStatus(tcStatus)
  );

  always #5 CLK = ~CLK;

  // One clock: sample on the falling edge; the CPU grants hold whenever asked.
  task automatic cycle();
    @(negedge CLK);
    cyc++;
    HLDA = HRQ;
    if (xferStrobe) begin
      obs_addr.push_back(ADDR);
      obs_dack.push_back(DACK);
      obs_cyc.push_back(cyc);
    end
    if (intEOP) eop_cnt++;
    if (HRQ && !hrq_prev) hrq_rise++;
    hrq_prev = HRQ;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_dack.delete(); obs_cyc.delete();
    exp_addr.delete(); exp_ch.delete();
    eop_cnt = 0; hrq_rise = 0; hrq_prev = HRQ;
  endtask

  task automatic prog(input int c, input logic [15:0] a, input logic [15:0] n);
    progWe = 1'b1; progCh = 2'(c); progAddr = a; progCount = n;
    cycle();
    progWe = 1'b0;
    m_addr[c] = a; m_cnt[c] = n; m_tc[c] = 1'b0;
  endtask

  task automatic set_mode(input int c, input logic [1:0] m);
    modeSel[2*c +: 2] = m;
  endtask

  // A channel moves n words (stopping early at terminal count) at consecutive addresses.
  task automatic model_words(input int c, input int n);
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back(m_addr[c]);
      exp_ch.push_back(c);
      if (m_cnt[c] == 16'd0) m_tc[c] = 1'b1;
      m_addr[c] = m_addr[c] + 16'd1;
      m_cnt[c]  = m_cnt[c] - 16'd1;
      if (m_tc[c]) break;
    end
  endtask

  function automatic int pick(input logic [3:0] elig, input logic rot);
    int b;
    b = rot ? m_ptr : 0;
    for (int k = 0; k < NUM_CH; k++)
      if (elig[(b + k) % NUM_CH]) return (b + k) % NUM_CH;
    return 0;
  endfunction

  task automatic wait_strobes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (obs_addr.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_tc(input int c, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (tcStatus[c]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    idle(2);
    checks++;
    if ({HRQ, xferStrobe, intEOP} !== 3'b000) begin
      failures++; $display("[TB] FAIL reset_ctrl: got %b expected 000", {HRQ, xferStrobe, intEOP});
    end
    checks++;
    if (DACK !== 4'b0000) begin failures++; $display("[TB] FAIL reset_dack: got %b expected 0000", DACK); end
    checks++;
    if (ADDR !== 16'h0000) begin failures++; $display("[TB] FAIL reset_addr: got %h expected 0000", ADDR); end
    checks++;
    if (tcStatus !== 4'b0000) begin failures++; $display("[TB] FAIL reset_tc: got %b expected 0000", tcStatus); end
    RESET = 1'b0;
    idle(3);
    checks++;
    if (HRQ !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle_hrq: got %b expected 0", HRQ); end
  endtask

  task automatic test_single();
    bit ok;
    clear_obs();
    set_mode(0, 2'b01);
    prog(0, 16'h0011, 16'd2);
    model_words(0, 1000);
    DREQ = 4'b0001;
    wait_tc(0, 200, ok);
    DREQ = 4'b0000;
    m_ptr = 1;
    idle(4);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("[TB] FAIL single_timeout: got %b expected 1", ok); end
    checks++;
    if (obs_addr.size() != exp_addr.size()) begin
      failures++; $display("[TB] FAIL single_words: got %0d expected %0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_dack[i] !== 4'b0001) begin
        failures++; $display("[TB] FAIL single_word%0d: got %h/%b expected %h/0001", i, obs_addr[i], obs_dack[i], exp_addr[i]);
      end
    end
    checks++;
    if (hrq_rise != 3) begin failures++; $display("[TB] FAIL single_hrq_rises: got %0d expected 3", hrq_rise); end
    checks++;
    if (eop_cnt != 1) begin failures++; $display("[TB] FAIL single_inteop: got %0d expected 1", eop_cnt); end
    checks++;
    if (tcStatus !== m_tc) begin failures++; $display("[TB] FAIL single_tc: got %b expected %b", tcStatus, m_tc); end
  endtask

  task automatic test_block();
    bit ok;
    clear_obs();
    set_mode(2, 2'b10);
    prog(2, 16'hFFFE, 16'd3);
    model_words(2, 1000);
    DREQ = 4'b0100;
    wait_tc(2, 200, ok);
    DREQ = 4'b0000;
    m_ptr = 3;
    idle(4);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("[TB] FAIL block_timeout: got %b expected 1", ok); end
    checks++;
    if (obs_addr.size() != exp_addr.size()) begin
      failures++; $display("[TB] FAIL block_words: got %0d expected %0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_dack[i] !== 4'b0100) begin
        failures++; $display("[TB] FAIL block_word%0d: got %h/%b expected %h/0100", i, obs_addr[i], obs_dack[i], exp_addr[i]);
      end
      if (i > 0) begin
        checks++;
        if (obs_cyc[i] - obs_cyc[i-1] != 2) begin
          failures++; $display("[TB] FAIL block_spacing%0d: got %0d expected 2", i, obs_cyc[i] - obs_cyc[i-1]);
        end
      end
    end
    checks++;
    if (hrq_rise != 1) begin failures++; $display("[TB] FAIL block_hrq_rises: got %0d expected 1", hrq_rise); end
    checks++;
    if (tcStatus !== m_tc) begin failures++; $display("[TB] FAIL block_tc: got %b expected %b", tcStatus, m_tc); end
  endtask

  task automatic test_priority();
    bit ok;
    logic [3:0] masks[5];
    logic       rots[5];
    int         ns[5];
    int         w;
    masks = '{4'b1010, 4'b1010, 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))};
    rots  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ns    = '{1, 1, 4, 4, 3};
    for (int c = 0; c < NUM_CH; c++) begin
      set_mode(c, 2'b01);
      prog(c, 16'($urandom), 16'd20);
    end
    for (int p = 0; p < 5; p++) begin
      clear_obs();
      rotatePriority = rots[p];
      for (int k = 0; k < ns[p]; k++) begin
        w = pick(masks[p] & ~m_tc, rots[p]);
        model_words(w, 1);
        m_ptr = (w + 1) % NUM_CH;
      end
      DREQ = masks[p];
      wait_strobes(ns[p], 40 * ns[p], ok);
      DREQ = 4'b0000;
      idle(5);
      checks++;
      if (ok !== 1'b1 || obs_addr.size() != exp_addr.size()) begin
        failures++; $display("[TB] FAIL prio_phase%0d_words: got %0d expected %0d", p, obs_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
        checks++;
        if (obs_dack[i] !== 4'(1 << exp_ch[i]) || obs_addr[i] !== exp_addr[i]) begin
          failures++; $display("[TB] FAIL prio_phase%0d_word%0d: got %b/%h expected %b/%h",
                               p, i, obs_dack[i], obs_addr[i], 4'(1 << exp_ch[i]), exp_addr[i]);
        end
      end
    end
    rotatePriority = 1'b0;
  endtask

  task automatic test_demand();
    bit ok;
    logic [15:0] a;
    a = 16'($urandom);
    clear_obs();
    set_mode(0, 2'b00);
    prog(0, a, 16'd9);
    model_words(0, 2);
    DREQ = 4'b0001;
    wait_strobes(2, 60, ok);
    DREQ = 4'b0000;
    m_ptr = 1;
    idle(5);
    checks++;
    if (ok !== 1'b1 || obs_addr.size() != 2) begin
      failures++; $display("[TB] FAIL demand_words: got %0d expected 2", obs_addr.size());
    end
    checks++;
    if (tcStatus !== m_tc || eop_cnt != 0) begin
      failures++; $display("[TB] FAIL demand_tc: got %b/%0d expected %b/0", tcStatus, eop_cnt, m_tc);
    end
    clear_obs();
    model_words(0, 1000);
    DREQ = 4'b0001;
    wait_tc(0, 200, ok);
    DREQ = 4'b0000;
    idle(4);
    checks++;
    if (ok !== 1'b1 || obs_addr.size() != exp_addr.size()) begin
      failures++; $display("[TB] FAIL demand_resume_words: got %0d expected %0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i]) begin
        failures++; $display("[TB] FAIL demand_resume_word%0d: got %h expected %h", i, obs_addr[i], exp_addr[i]);
      end
    end
    checks++;
    if (eop_cnt != 1 || hrq_rise != 1) begin
      failures++; $display("[TB] FAIL demand_resume_eop_hrq: got %0d/%0d expected 1/1", eop_cnt, hrq_rise);
    end
  endtask

  task automatic test_ext_eop();
    bit ok;
    clear_obs();
    set_mode(1, 2'b10);
    prog(1, 16'($urandom), 16'd5);
    model_words(1, 2);
    DREQ = 4'b0010;
    wait_strobes(2, 60, ok);
    extEOP = 1'b1;
    DREQ = 4'b0000;
    cycle();
    extEOP = 1'b0;
    m_ptr = 2;
    idle(5);
    checks++;
    if (ok !== 1'b1 || obs_addr.size() != 2) begin
      failures++; $display("[TB] FAIL eop_words: got %0d expected 2", obs_addr.size());
    end
    checks++;
    if (eop_cnt != 0 || tcStatus !== m_tc) begin
      failures++; $display("[TB] FAIL eop_no_tc: got %0d/%b expected 0/%b", eop_cnt, tcStatus, m_tc);
    end
    clear_obs();
    model_words(1, 1000);
    DREQ = 4'b0010;
    wait_tc(1, 200, ok);
    DREQ = 4'b0000;
    idle(4);
    checks++;
    if (ok !== 1'b1 || obs_addr.size() != exp_addr.size()) begin
      failures++; $display("[TB] FAIL eop_resume_words: got %0d expected %0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i]) begin
        failures++; $display("[TB] FAIL eop_resume_word%0d: got %h expected %h", i, obs_addr[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_obs();
    set_mode(3, 2'b10);
    prog(3, 16'($urandom), 16'd5);
    DREQ = 4'b1000;
    wait_strobes(1, 60, ok);
    RESET = 1'b1;
    DREQ = 4'b0000;
    #1;
    checks++;
    if (ok !== 1'b1 || {HRQ, xferStrobe, intEOP} !== 3'b000 || DACK !== 4'b0000 || ADDR !== 16'h0000) begin
      failures++; $display("[TB] FAIL reset_mid_outputs: got %b/%b/%h expected 000/0000/0000",
                           {HRQ, xferStrobe, intEOP}, DACK, ADDR);
    end
    for (int c = 0; c < NUM_CH; c++) begin m_addr[c] = 16'h0; m_cnt[c] = 16'h0; end
    m_tc = 4'b0000;
    m_ptr = 0;
    idle(2);
    RESET = 1'b0;
    clear_obs();
    idle(6);
    checks++;
    if (obs_addr.size() != 0 || hrq_rise != 0) begin
      failures++; $display("[TB] FAIL reset_mid_quiet: got %0d strobes %0d hrq expected 0/0", obs_addr.size(), hrq_rise);
    end
    checks++;
    if (tcStatus !== m_tc) begin failures++; $display("[TB] FAIL reset_mid_tc: got %b expected %b", tcStatus, m_tc); end
  endtask

  task automatic test_cs_n();
    bit ok;
    clear_obs();
    set_mode(0, 2'b01);
    prog(0, 16'($urandom), 16'd0);
    model_words(0, 1000);
    CS_N = 1'b0;
    DREQ = 4'b0001;
    idle(5);
    checks++;
    if (hrq_rise != 0 || HRQ !== 1'b0) begin
      failures++; $display("[TB] FAIL csn_blocks: got %0d/%b expected 0/0", hrq_rise, HRQ);
    end
    CS_N = 1'b1;
    cycle();
    checks++;
    if (HRQ !== 1'b1) begin failures++; $display("[TB] FAIL csn_release_hrq: got %b expected 1", HRQ); end
    CS_N = 1'b0;
    wait_tc(0, 60, ok);
    DREQ = 4'b0000;
    CS_N = 1'b1;
    m_ptr = 1;
    idle(4);
    checks++;
    if (ok !== 1'b1 || obs_addr.size() != 1) begin
      failures++; $display("[TB] FAIL csn_service_words: got %0d expected 1", obs_addr.size());
    end else begin
      checks++;
      if (obs_addr[0] !== exp_addr[0]) begin
        failures++; $display("[TB] FAIL csn_service_addr: got %h expected %h", obs_addr[0], exp_addr[0]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int c, n;
    logic [1:0] m;
    for (int it = 0; it < 8; it++) begin
      c = $urandom_range(0, NUM_CH - 1);
      m = 2'($urandom_range(0, 3));
      clear_obs();
      set_mode(c, m);
      prog(c, 16'($urandom), 16'($urandom_range(0, 5)));
      model_words(c, 1000);
      n = exp_addr.size();
      DREQ = 4'(1 << c);
      wait_tc(c, 300, ok);
      DREQ = 4'b0000;
      m_ptr = (c + 1) % NUM_CH;
      idle(4);
      checks++;
      if (ok !== 1'b1 || obs_addr.size() != n) begin
        failures++; $display("[TB] FAIL rand%0d_words: got %0d expected %0d (ch %0d mode %b)", it, obs_addr.size(), n, c, m);
      end
      for (int i = 0; i < n && i < obs_addr.size(); i++) begin
        checks++;
        if (obs_addr[i] !== exp_addr[i] || obs_dack[i] !== 4'(1 << c)) begin
          failures++; $display("[TB] FAIL rand%0d_word%0d: got %h/%b expected %h/%b", it, i, obs_addr[i], obs_dack[i], exp_addr[i], 4'(1 << c));
        end
      end
      checks++;
      if (hrq_rise != ((m[0] == 1'b1) ? n : 1)) begin
        failures++; $display("[TB] FAIL rand%0d_hrq_rises: got %0d expected %0d", it, hrq_rise, (m[0] == 1'b1) ? n : 1);
      end
      checks++;
      if (eop_cnt != 1 || tcStatus !== m_tc) begin
        failures++; $display("[TB] FAIL rand%0d_tc: got %0d/%b expected 1/%b", it, eop_cnt, tcStatus, m_tc);
      end
    end
  endtask

  initial begin
    RESET = 1'b1; CS_N = 1'b1; HLDA = 1'b0; extEOP = 1'b0; rotatePriority = 1'b0;
    progWe = 1'b0; progCh = '0; progAddr = '0; progCount = '0;
    DREQ = '0; modeSel = '0;
    cyc = 0; hrq_prev = 1'b0; eop_cnt = 0; hrq_rise = 0;
    for (int c = 0; c < NUM_CH; c++) begin m_addr[c] = 16'h0; m_cnt[c] = 16'h0; end
    m_tc = 4'b0000;
    m_ptr = 0;
    test_reset();
    test_single();
    test_block();
    test_priority();
    test_demand();
    test_ext_eop();
    test_reset_mid();
    test_cs_n();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_transfer_sequencer.md
DMA_TRANSFER_SEQUENCER -- requirements
Module: dma_transfer_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of DMA channels (2..8).
REQ-002 SHALL have parameter ADDR_W, default 16, address register width.
REQ-003 SHALL have parameter CNT_W, default 16, word count register width.
REQ-004 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port CS_N  input  1  active-low program condition; while low, no new service starts.
REQ-007 SHALL have port DREQ  input  NUM_CH  per-channel DMA request, active-high.
REQ-008 SHALL have port HLDA  input  1  hold acknowledge from CPU.
REQ-009 SHALL have port extEOP  input  1  external end-of-process, active-high.
REQ-010 SHALL have port modeSel  input  2*NUM_CH  per-channel mode: 00 demand, 01 single, 10 block, 11 treated as single.
REQ-011 SHALL have port rotatePriority  input  1  0 fixed priority (channel 0 highest), 1 rotating.
REQ-012 SHALL have port progWe  input  1  one-cycle load strobe for channel registers.
REQ-013 SHALL have port progCh  input  $clog2(NUM_CH)  channel selected by progWe.
REQ-014 SHALL have ports progAddr  input  ADDR_W and progCount  input  CNT_W  load values.
REQ-015 SHALL have port HRQ  output  1  hold request to CPU.
REQ-016 SHALL have port DACK  output  NUM_CH  one-hot acknowledge of the serviced channel.
REQ-017 SHALL have port ADDR  output  ADDR_W  current transfer address.
REQ-018 SHALL have port xferStrobe  output  1  high exactly one cycle per word transferred.
REQ-019 SHALL have ports intEOP  output  1  terminal-count pulse, and tcStatus  output  NUM_CH  sticky TC flags.

Function
REQ-020 SHALL implement states IDLE, HOLD_REQ, ARB, XFER, UPDATE.
REQ-021 IDLE: when CS_N=1 and any DREQ[i]=1 with tcStatus[i]=0, SHALL go to HOLD_REQ; HRQ=1 from the next cycle.
REQ-022 HOLD_REQ: SHALL hold HRQ=1 until HLDA=1, then go to ARB.
REQ-023 ARB (1 cycle): SHALL latch the highest-priority eligible channel; if none remain, return to IDLE with HRQ=0.
REQ-024 Rotating priority: after a channel completes service, it SHALL become lowest priority and channel+1 (mod NUM_CH) highest.
REQ-025 XFER (1 cycle): SHALL drive DACK one-hot for the channel, ADDR=addr[ch], xferStrobe=1.
REQ-026 UPDATE (1 cycle): addr[ch] SHALL increment modulo 2^ADDR_W; count[ch] SHALL decrement modulo 2^CNT_W; DACK stays asserted.
REQ-027 A channel SHALL transfer progCount+1 words; TC occurs on the UPDATE in which count[ch] was 0.
REQ-028 On TC: intEOP=1 for that one cycle, tcStatus[ch] set, go to IDLE, HRQ/DACK low the next cycle.
REQ-029 Without TC: single SHALL go to IDLE; block SHALL go to XFER; demand SHALL go to XFER if DREQ[ch]=1, else IDLE.
REQ-030 extEOP=1 during XFER or UPDATE SHALL terminate the service after the current UPDATE (registers updated), go to IDLE, without setting tcStatus or pulsing intEOP.
REQ-031 HLDA falling in ARB, XFER or UPDATE SHALL finish the current UPDATE if in XFER/UPDATE, then go to IDLE; DACK=0 and HRQ=0 the next cycle.
REQ-032 progWe SHALL load addr/count of progCh and clear tcStatus[progCh]; a write to the channel currently in XFER/UPDATE SHALL be ignored.
REQ-033 A channel with tcStatus=1 SHALL be ineligible until reprogrammed.
REQ-034 Outside XFER/UPDATE, DACK=0, xferStrobe=0, ADDR=0.
REQ-035 CS_N low SHALL NOT abort a service in progress.

Reset
REQ-036 RESET=1 SHALL immediately force IDLE, HRQ=0, DACK=0, ADDR=0, xferStrobe=0, intEOP=0, tcStatus=0, all addr/count registers 0, priority pointer to channel 0.
REQ-037 Reset asserted mid-transfer SHALL abandon the transfer with no further strobe; the first service after release requires a new DREQ/HLDA handshake.

Verification
REQ-038 Single mode: program ch0 addr=0x0011 count=2, DREQ=0001, HLDA follows HRQ -> 3 strobes at ADDR 0x0011,0x0012,0x0013, HRQ dropped between words, intEOP on third UPDATE, tcStatus=0001.
REQ-039 Block mode: ch2 addr=0xFFFE count=3 -> 4 consecutive strobes every 2 cycles, ADDR 0xFFFE,0xFFFF,0x0000,0x0001, one HRQ assertion.
REQ-040 Priority: DREQ=1010, all single, rotatePriority=0 -> ch1 serviced before ch3; rotatePriority=1 after ch1 service -> ch3 next.
REQ-041 Demand mode: ch0 count=9, DREQ dropped after 2nd strobe -> exactly 2 strobes, count=7, tcStatus=0, re-raising DREQ resumes at addr+2.
REQ-042 Abort: extEOP during 2nd block transfer -> 2 strobes, no intEOP, tcStatus=0; RESET during XFER -> all outputs 0 same cycle.
REQ-043 CS_N=0 with DREQ=0001 -> HRQ stays 0; CS_N to 1 -> HRQ=1 next cycle.
